// File: rtl/shift_sched_pkg.sv
// Shared types for the shift scheduler:
// op encodings and the sequencer state enum.
package shift_sched_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        EXEC2 = 2'b10,
        RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/shift_scheduler_shifter.sv
// Combinational barrel shifter: logical left,
// logical right or arithmetic right by Shift_Val.
module BarrelShifter #(
    parameter int N = 32
) (
    input  logic [N-1:0]         Data,
    input  logic [$clog2(N)-1:0] Shift_Val,
    input  logic                 Left_Right,
    input  logic                 Logic_Arithmetic,
    output logic [N-1:0]         Result
);

    logic       fill;
    logic [N:0] ext;

    // Right shifts sign-extend only when arithmetic is selected.
    always_comb begin
        fill = Left_Right & Logic_Arithmetic & Data[N-1];
        ext  = {fill, Data};
        if (Left_Right) begin
            ext = $signed(ext) >>> Shift_Val;
        end else begin
            ext = {1'b0, Data << Shift_Val};
        end
        Result = ext[N-1:0];
    end

endmodule

// File: rtl/shift_scheduler.sv
// Round-robin scheduler sharing one barrel shifter
// between two requesters; ROR takes two passes.
module shift_scheduler
    import shift_sched_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Req0_Valid,
    output logic                 Req0_Ready,
    input  logic [N-1:0]         Req0_Data,
    input  logic [$clog2(N)-1:0] Req0_Shift,
    input  logic [1:0]           Req0_Op,
    input  logic                 Req1_Valid,
    output logic                 Req1_Ready,
    input  logic [N-1:0]         Req1_Data,
    input  logic [$clog2(N)-1:0] Req1_Shift,
    input  logic [1:0]           Req1_Op,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [N-1:0]         Out_Data,
    output logic                 Out_Id,
    output logic                 Busy,
    output logic [CNT_W-1:0]     Op_Count
);

    localparam int SW = $clog2(N);

    state_e         state_q, state_d;
    logic           last_q, last_d;
    logic [N-1:0]   data_q, data_d;
    logic [SW-1:0]  shift_q, shift_d;
    op_e            op_q, op_d;
    logic           id_q, id_d;
    logic [N-1:0]   partial_q, partial_d;
    logic [N-1:0]   out_data_q, out_data_d;
    logic           out_id_q, out_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic           grant;
    logic           idle;
    logic           sh_lr;
    logic           sh_la;
    logic [SW-1:0]  sh_amt;
    logic [N-1:0]   sh_res;

    // Round-robin grant; a tie goes to whoever did not win last.
    always_comb begin
        idle       = (state_q == IDLE);
        grant      = (Req0_Valid & Req1_Valid) ? ~last_q : Req1_Valid;
        Req0_Ready = idle & Req0_Valid & ~grant;
        Req1_Ready = idle & Req1_Valid & grant;
    end

    // Shifter control from captured operands; EXEC2 is the ROR wrap pass.
    always_comb begin
        sh_lr  = 1'b0;
        sh_la  = 1'b0;
        sh_amt = shift_q;
        unique case (op_q)
            OP_LSL: begin
                sh_lr = 1'b0;
            end
            OP_LSR: begin
                sh_lr = 1'b1;
            end
            OP_ASR: begin
                sh_lr = 1'b1;
                sh_la = 1'b1;
            end
            OP_ROR: begin
                if (state_q == EXEC2) begin
                    sh_lr  = 1'b0;
                    sh_amt = '0 - shift_q;
                end else begin
                    sh_lr  = 1'b1;
                end
            end
            default: begin
                sh_lr = 1'b0;
            end
        endcase
    end

    BarrelShifter #(
        .N(N)
    ) u_shifter (
        .Data             (data_q),
        .Shift_Val        (sh_amt),
        .Left_Right       (sh_lr),
        .Logic_Arithmetic (sh_la),
        .Result           (sh_res)
    );

    // Sequencer next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        data_d     = data_q;
        shift_d    = shift_q;
        op_d       = op_q;
        id_d       = id_q;
        partial_d  = partial_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (Req0_Ready | Req1_Ready) begin
                    last_d  = grant;
                    id_d    = grant;
                    data_d  = grant ? Req1_Data : Req0_Data;
                    shift_d = grant ? Req1_Shift : Req0_Shift;
                    op_d    = op_e'(grant ? Req1_Op : Req0_Op);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_q == OP_ROR && shift_q != '0) begin
                    partial_d = sh_res;
                    state_d   = EXEC2;
                end else begin
                    out_data_d = sh_res;
                    out_id_d   = id_q;
                    state_d    = RESP;
                end
            end
            EXEC2: begin
                out_data_d = partial_q | sh_res;
                out_id_d   = id_q;
                state_d    = RESP;
            end
            RESP: begin
                if (Out_Ready) begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            data_q     <= '0;
            shift_q    <= '0;
            op_q       <= OP_LSL;
            id_q       <= 1'b0;
            partial_q  <= '0;
            out_data_q <= '0;
            out_id_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            op_q       <= op_d;
            id_q       <= id_d;
            partial_q  <= partial_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            cnt_q      <= cnt_d;
        end
    end

    assign Out_Valid = (state_q == RESP);
    assign Out_Data  = out_data_q;
    assign Out_Id    = out_id_q;
    assign Busy      = (state_q != IDLE);
    assign Op_Count  = cnt_q;

endmodule

// File: doc/shift_scheduler.md
Name: shift_scheduler

Overview:
- Shares one combinational BarrelShifter datapath between two requesters in the ArithmeticUnit.
- Arbitrates round-robin and sequences each operation through the shifter.
- Adds rotate-right, done as two shifter passes OR-ed together; all other ops take one pass.
- Registers the result and returns it on a valid/ready port, tagged with the requester ID.

Parameters:
- N, 32: datapath width; power of two, >= 4.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Req0_Valid  in  1  requester 0 has an operation.
- Req0_Ready  out  1  requester 0 accepted this cycle.
- Req0_Data  in  N  requester 0 operand.
- Req0_Shift  in  $clog2(N)  requester 0 shift amount.
- Req0_Op  in  2  requester 0 op: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- Req1_Valid, Req1_Ready, Req1_Data, Req1_Shift, Req1_Op: same as requester 0, for requester 1.
- Out_Valid  out  1  result available.
- Out_Ready  in  1  consumer accepts the result.
- Out_Data  out  N  shifted result.
- Out_Id  out  1  ID of the requester that issued the result.
- Busy  out  1  high in any state other than IDLE.
- Op_Count  out  CNT_W  count of completed handshakes; wraps.

Behaviour:
- Reset (async, Reset_n=0):
  - State=IDLE; Out_Valid=0, Out_Data=0, Out_Id=0, Op_Count=0, Busy=0.
  - Last_Grant=1, so requester 0 wins the first tie.
  - Captured operand registers are cleared to 0.
  - Reset mid-operation abandons the operation silently; no output is produced.
- Arbitration:
  - Evaluated only in IDLE.
  - Grant g = requester 0 if only Req0_Valid is high; requester 1 if only Req1_Valid is high; if both are high, ~Last_Grant.
  - ReqX_Ready = (State==IDLE) & ReqX_Valid & (g==X). It is combinational from Valid and state, and at most one Ready is high.
  - Accept edge (IDLE, a Ready high): capture Data, Shift, Op and Id; set Last_Grant=g; go to EXEC.
- Shifter drive, from captured registers only:
  - LSL: Left_Right=0, Logic_Arithmetic=0.
  - LSR: Left_Right=1, Logic_Arithmetic=0.
  - ASR: Left_Right=1, Logic_Arithmetic=1.
  - ROR pass 1: Left_Right=1, Logic_Arithmetic=0, Shift_Val=Shift.
  - ROR pass 2: Left_Right=0, Shift_Val=N-Shift (mod 2^$clog2(N)).
- States:
  - IDLE: wait for an accept, then go to EXEC.
  - EXEC, non-ROR or ROR with Shift==0: register the shifter result into Out_Data, set Out_Id, go to RESP. ROR by 0 returns the operand unchanged.
  - EXEC, ROR with Shift!=0: store the pass-1 result in Partial; go to EXEC2.
  - EXEC2: Out_Data = Partial | shifter result; go to RESP.
  - RESP: Out_Valid=1. When Out_Ready=1: Op_Count+1 (wraps to 0 at 2^CNT_W), Out_Valid falls, go to IDLE.
- Latency, counted as edges after the accept edge:
  - Out_Valid rises after 1 edge for single-pass ops, 2 edges for ROR.
  - Maximum throughput is one operation per 3 cycles (4 for ROR).
- Backpressure: while in RESP with Out_Ready=0, Out_Data and Out_Id hold stable and both Req Ready outputs stay 0.
- Requester inputs are ignored outside the accept edge; changing them mid-operation has no effect.

Decomposition:
- Package shift_sched_pkg holds:
  - op encodings OP_LSL, OP_LSR, OP_ASR, OP_ROR;
  - the state enum IDLE, EXEC, EXEC2, RESP.
- Single sub-module: one instance of the existing BarrelShifter #(N). Its Result feeds the pass-1 register and the output register.
- The arbiter stays inline; it is too small to split out.

Test Plan (N=32):
- Single ops:
  - Req0 LSL, Data 0x00000001, Shift 31 -> Out_Data 0x80000000, Out_Id 0, Out_Valid 1 edge after accept.
  - Req1 ASR, Data 0x80000000, Shift 31 -> Out_Data 0xFFFFFFFF.
  - LSR of the same operand and shift -> Out_Data 0x00000001.
- Rotate:
  - ROR, Data 0x80000001, Shift 4 -> Out_Data 0x18000000, Out_Valid 2 edges after accept, state passes through EXEC2.
  - ROR, Data 0x12345678, Shift 0 -> Out_Data 0x12345678 after 1 edge.
- Round-robin: both Req Valid held high, Out_Ready=1 -> grant order 0,1,0,1; Op_Count reaches 4.
- Backpressure: Out_Ready=0 for 5 cycles in RESP -> Out_Valid, Out_Data and Out_Id stable; Req0_Ready and Req1_Ready stay 0; Op_Count increments once on release.
- Reset: pull Reset_n low in EXEC2 of an ROR -> outputs reset immediately and no result appears. After release, both Valid high -> requester 0 granted first.
- Counter wrap: run with CNT_W=4 for 17 operations -> Op_Count reads 1.
